usb_fs_out_ep_buffer: RTL and testbench

//  Consumes the decoded receive-path outputs (pkt_start/pkt_end, pid, addr, endp,
//  rx_data_put/rx_data, valid_packet). Captures the DATA0/DATA1 payload that follows
//  an OUT token addressed to this device/endpoint into a circular byte buffer.

---
 rtl/usb_fs_pkg.sv | 13 +
 rtl/usb_fs_out_ep_ram.sv | 34 +++
 rtl/usb_fs_out_ep_buffer.sv | 159 +++++++++++++++
 tb/tb_usb_fs_out_ep_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_pkg.sv
// Shared USB full-speed receive-path constants: PIDs, CRC length, OUT endpoint FSM states.
package usb_fs_pkg;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam int         CRC_BYTES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RECV  = 2'd2
    } out_ep_state_e;
endpackage

// File: rtl/usb_fs_out_ep_ram.sv
// DEPTH x 8 simple dual-port byte RAM, synchronous read with a resettable output register.
module usb_fs_out_ep_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_addr];
    end

    // Storage array carries no reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) rd_data_q <= 8'h00;
        else          rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/usb_fs_out_ep_buffer.sv
// USB FS OUT endpoint buffer: speculative write of DATA payload, commit on good packet end.
// Define USB_OUT_TOGGLE_CHECK_EN to track the expected DATA0/DATA1 toggle.
module usb_fs_out_ep_buffer
    import usb_fs_pkg::*;
#(
    parameter logic [3:0] ENDP    = 4'd1,
    parameter int         DEPTH   = 128,
    parameter int         MAX_PKT = 64,
    parameter int         AW      = $clog2(DEPTH),
    parameter int         PW      = AW + 1
) (
    input  logic          clk_48mhz,
    input  logic          reset_n,
    input  logic [6:0]    dev_addr,
    input  logic          toggle_clr,
    input  logic          rx_pkt_start,
    input  logic          rx_pkt_end,
    input  logic [3:0]    rx_pid,
    input  logic [6:0]    rx_addr,
    input  logic [3:0]    rx_endp,
    input  logic          rx_data_put,
    input  logic [7:0]    rx_data,
    input  logic          rx_pkt_valid,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic [PW-1:0] count,
    output logic          out_ack,
    output logic          out_nak
);
    localparam int BW = $clog2(MAX_PKT + CRC_BYTES + 1);

    out_ep_state_e state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BW-1:0] bytes_q, bytes_d;
    logic          ovf_q, ovf_d, ack_q, ack_d, nak_q, nak_d;
    logic          ram_we, rd_accept, full, pid_is_data, token_hit;

    assign empty       = (rd_ptr_q == cm_ptr_q);
    assign count       = cm_ptr_q - rd_ptr_q;
    assign rd_accept   = rd_en && !empty;
    assign full        = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
    assign pid_is_data = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
    assign token_hit   = rx_pkt_valid && (rx_pid == PID_OUT) &&
                         (rx_addr == dev_addr) && (rx_endp == ENDP);

`ifdef USB_OUT_TOGGLE_CHECK_EN
    logic toggle_q, toggle_d;
`else
    logic unused_toggle_clr;
    assign unused_toggle_clr = toggle_clr;
`endif

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        rd_ptr_d = rd_ptr_q;
        bytes_d  = bytes_q;
        ovf_d    = ovf_q;
        ack_d    = 1'b0;
        nak_d    = 1'b0;
        ram_we   = 1'b0;
`ifdef USB_OUT_TOGGLE_CHECK_EN
        toggle_d = toggle_q;
`endif
        if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);

        case (state_q)
            ST_IDLE: begin
                if (rx_pkt_end && !rx_pkt_start && token_hit) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (rx_pkt_start) begin
                    state_d  = ST_RECV;
                    wr_ptr_d = cm_ptr_q;
                    bytes_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            ST_RECV: begin
                if (rx_data_put) begin
                    if (full || bytes_q == BW'(MAX_PKT + CRC_BYTES)) begin
                        ovf_d = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        bytes_d  = bytes_q + BW'(1);
                    end
                end
                if (rx_pkt_end) begin
                    state_d = ST_IDLE;
                    if (!rx_pkt_valid || !pid_is_data || bytes_q < BW'(CRC_BYTES)) begin
                        state_d = ST_IDLE;
                    end else if (ovf_q) begin
                        nak_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
`ifdef USB_OUT_TOGGLE_CHECK_EN
                        // A toggle mismatch is a host retransmit: ack it but keep old data.
                        if (rx_pid[3] == toggle_q) begin
                            cm_ptr_d = wr_ptr_q - PW'(CRC_BYTES);
                            toggle_d = ~toggle_q;
                        end
`else
                        cm_ptr_d = wr_ptr_q - PW'(CRC_BYTES);
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef USB_OUT_TOGGLE_CHECK_EN
        if (toggle_clr) toggle_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
            bytes_q  <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            nak_q    <= 1'b0;
`ifdef USB_OUT_TOGGLE_CHECK_EN
            toggle_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            bytes_q  <= bytes_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            nak_q    <= nak_d;
`ifdef USB_OUT_TOGGLE_CHECK_EN
            toggle_q <= toggle_d;
`endif
        end
    end

    assign out_ack = ack_q;
    assign out_nak = nak_q;

    usb_fs_out_ep_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk_48mhz),
        .reset_n (reset_n),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (rx_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_usb_fs_out_ep_buffer.sv
// Directed bench for usb_fs_out_ep_buffer: token/data packet sequences, commit, nak, reads.
module tb_usb_fs_out_ep_buffer;
    import usb_fs_pkg::*;

    localparam logic [6:0] DEV = 7'h2A;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] dev_addr = DEV;
    logic       toggle_clr = 1'b0;
    logic       rx_pkt_start = 1'b0, rx_pkt_end = 1'b0, rx_data_put = 1'b0, rx_pkt_valid = 1'b0;
    logic [3:0] rx_pid = 4'h0, rx_endp = 4'h0;
    logic [6:0] rx_addr = 7'h0;
    logic [7:0] rx_data = 8'h0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty, out_ack, out_nak;
    logic [7:0] count;

    int n_chk = 0, n_pass = 0;
    logic [7:0] pl [0:127];
    logic       got_ack, got_nak;
    logic [7:0] rb;
    bit         tgl_en;

    always #10 clk = ~clk;

    usb_fs_out_ep_buffer dut (
        .clk_48mhz(clk), .reset_n(reset_n), .dev_addr(dev_addr), .toggle_clr(toggle_clr),
        .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pid(rx_pid),
        .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_data_put(rx_data_put), .rx_data(rx_data),
        .rx_pkt_valid(rx_pkt_valid), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
        .count(count), .out_ack(out_ack), .out_nak(out_nak)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic token(input logic [6:0] a, input logic [3:0] e);
        rx_pkt_start = 1'b1; rx_pid = PID_OUT; cyc();
        rx_pkt_start = 1'b0;
        rx_pkt_end = 1'b1; rx_pkt_valid = 1'b1; rx_addr = a; rx_endp = e; cyc();
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
    endtask

    // Sends pl[0..n-1] plus two CRC bytes, then samples the handshake pulse.
    task automatic data(input logic [3:0] pid, input int n, input logic ok);
        rx_pkt_start = 1'b1; rx_pid = pid; cyc();
        rx_pkt_start = 1'b0;
        for (int i = 0; i < n + 2; i++) begin
            rx_data_put = 1'b1;
            rx_data = (i < n) ? pl[i] : 8'hC0 + 8'(i - n);
            cyc();
        end
        rx_data_put = 1'b0;
        rx_pkt_end = 1'b1; rx_pkt_valid = ok; cyc();
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        got_ack = out_ack; got_nak = out_nak;
    endtask

    task automatic rd(output logic [7:0] d);
        rd_en = 1'b1; cyc();
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic clr_toggle();
        toggle_clr = 1'b1; cyc();
        toggle_clr = 1'b0;
    endtask

    initial begin
`ifdef USB_OUT_TOGGLE_CHECK_EN
        tgl_en = 1'b1;
`else
        tgl_en = 1'b0;
`endif
        repeat (3) cyc();
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_ack", int'(out_ack), 0);
        chk("rst_nak", int'(out_nak), 0);
        reset_n = 1'b1; cyc();

        // Basic 4-byte DATA0 commit and read-out
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        token(DEV, 4'd1); data(PID_DATA0, 4, 1'b1);
        chk("basic_ack", int'(got_ack), 1);
        chk("basic_nak", int'(got_nak), 0);
        chk("basic_count", int'(count), 4);
        cyc();
        chk("ack_one_cycle", int'(out_ack), 0);
        for (int i = 0; i < 4; i++) begin
            rd(rb);
            chk($sformatf("basic_rd%0d", i), int'(rb), 8'h11 * (i + 1));
        end
        chk("basic_empty", int'(empty), 1);

        // Bad CRC/PID at end: silent drop
        token(DEV, 4'd1); data(PID_DATA0, 4, 1'b0);
        chk("bad_ack", int'(got_ack), 0);
        chk("bad_nak", int'(got_nak), 0);
        chk("bad_count", int'(count), 0);

        // Wrong endpoint: ignored
        token(DEV, 4'd2); data(PID_DATA0, 4, 1'b1);
        chk("ep2_ack", int'(got_ack), 0);
        chk("ep2_nak", int'(got_nak), 0);
        chk("ep2_count", int'(count), 0);

        // Read while empty is ignored
        rd(rb);
        chk("rd_empty_count", int'(count), 0);
        chk("rd_empty_empty", int'(empty), 1);

        // Fill to 100 bytes, then a 64-byte packet cannot fit -> nak
        clr_toggle();
        for (int i = 0; i < 64; i++) pl[i] = 8'(i + 1);
        token(DEV, 4'd1); data(PID_DATA0, 64, 1'b1);
        chk("fill1_ack", int'(got_ack), 1);
        for (int i = 0; i < 36; i++) pl[i] = 8'h80 + 8'(i);
        token(DEV, 4'd1); data(PID_DATA1, 36, 1'b1);
        chk("fill2_ack", int'(got_ack), 1);
        chk("fill_count", int'(count), 100);
        for (int i = 0; i < 64; i++) pl[i] = 8'hEE;
        token(DEV, 4'd1); data(PID_DATA0, 64, 1'b1);
        chk("full_nak", int'(got_nak), 1);
        chk("full_ack", int'(got_ack), 0);
        chk("full_count", int'(count), 100);
        for (int i = 0; i < 100; i++) begin
            rd(rb);
            chk($sformatf("fill_rd%0d", i), int'(rb), (i < 64) ? i + 1 : 8'h80 + i - 64);
        end
        chk("fill_drained", int'(empty), 1);

        // Babble: 65-byte payload into an empty buffer
        for (int i = 0; i < 65; i++) pl[i] = 8'(i);
        token(DEV, 4'd1); data(PID_DATA0, 65, 1'b1);
        chk("babble_nak", int'(got_nak), 1);
        chk("babble_ack", int'(got_ack), 0);
        chk("babble_count", int'(count), 0);

        // Two consecutive DATA0: second is a retransmit when toggles are tracked
        clr_toggle();
        pl[0] = 8'hA1; pl[1] = 8'hA2;
        token(DEV, 4'd1); data(PID_DATA0, 2, 1'b1);
        chk("tg1_ack", int'(got_ack), 1);
        pl[0] = 8'hB1; pl[1] = 8'hB2;
        token(DEV, 4'd1); data(PID_DATA0, 2, 1'b1);
        chk("tg2_ack", int'(got_ack), 1);
        chk("tg_count", int'(count), tgl_en ? 2 : 4);
        rd(rb); chk("tg_rd0", int'(rb), 8'hA1);
        rd(rb); chk("tg_rd1", int'(rb), 8'hA2);
        if (!tgl_en) begin
            rd(rb); chk("tg_rd2", int'(rb), 8'hB1);
            rd(rb); chk("tg_rd3", int'(rb), 8'hB2);
        end
        chk("tg_empty", int'(empty), 1);

        // Zero-length DATA1 (expected toggle is DATA1 here when tracked)
        token(DEV, 4'd1); data(PID_DATA1, 0, 1'b1);
        chk("zlp_ack", int'(got_ack), 1);
        chk("zlp_nak", int'(got_nak), 0);
        chk("zlp_count", int'(count), 0);

        // Reset mid-RECV discards committed data too
        clr_toggle();
        pl[0] = 8'hC1; pl[1] = 8'hC2;
        token(DEV, 4'd1); data(PID_DATA0, 2, 1'b1);
        chk("pre_rst_count", int'(count), 2);
        token(DEV, 4'd1);
        rx_pkt_start = 1'b1; rx_pid = PID_DATA1; cyc();
        rx_pkt_start = 1'b0;
        rx_data_put = 1'b1; rx_data = 8'h55; cyc(); cyc();
        rx_data_put = 1'b0;
        reset_n = 1'b0; cyc(); cyc();
        reset_n = 1'b1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_rd_data", int'(rd_data), 0);
        rx_pkt_end = 1'b1; rx_pkt_valid = 1'b1; cyc();
        rx_pkt_end = 1'b0; rx_pkt_valid = 1'b0;
        chk("mid_rst_idle_ack", int'(out_ack), 0);
        chk("mid_rst_idle_count", int'(count), 0);
        pl[0] = 8'hD1;
        token(DEV, 4'd1); data(PID_DATA0, 1, 1'b1);
        chk("post_rst_ack", int'(got_ack), 1);
        chk("post_rst_count", int'(count), 1);
        rd(rb); chk("post_rst_rd", int'(rb), 8'hD1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
